// File: rtl/layer_sequencer_if.sv
// Handshake bundle between layer_sequencer, the shared neuron engine and the
// neighbouring layers. LAYER_SEQUENCER_ARGMAX_EN adds the max_index/max_value pair.
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef FRACTION_WIDTH
`define FRACTION_WIDTH 8
`endif

interface layer_sequencer_if #(
    parameter int NUM_NEURONS = 10
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                                              inputs_ready;
    logic [IDX_W-1:0]                                  neuron_index;
    logic                                              neuron_start;
    logic                                              neuron_done;
    logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH]   neuron_out;
    logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH]   outputs [NUM_NEURONS];
    logic                                              outputs_ready;
    logic                                              busy;
`ifdef LAYER_SEQUENCER_ARGMAX_EN
    logic [IDX_W-1:0]                                  max_index;
    logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH]   max_value;
`endif

    // Sequencer side: drives the engine controls and the stored layer vector.
    modport master (
`ifdef LAYER_SEQUENCER_ARGMAX_EN
        output max_index,
        output max_value,
`endif
        input  inputs_ready,
        input  neuron_done,
        input  neuron_out,
        output neuron_index,
        output neuron_start,
        output outputs,
        output outputs_ready,
        output busy
    );

    modport slave (
`ifdef LAYER_SEQUENCER_ARGMAX_EN
        input  max_index,
        input  max_value,
`endif
        output inputs_ready,
        output neuron_done,
        output neuron_out,
        input  neuron_index,
        input  neuron_start,
        input  outputs,
        input  outputs_ready,
        input  busy
    );
endinterface

// File: rtl/layer_sequencer.sv
// Time-shares one neuron engine across all outputs of a layer and collects the results.
// Optional feature macro: LAYER_SEQUENCER_ARGMAX_EN (running argmax of the layer outputs).
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef FRACTION_WIDTH
`define FRACTION_WIDTH 8
`endif

module layer_sequencer #(
    parameter int NUM_NEURONS = 10
) (
    input  logic              clock,
    input  logic              reset,
    layer_sequencer_if.master bus
);
    localparam int               IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH] data_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             accept;

    // A result is taken only while waiting and the run has not been aborted.
    assign accept           = (state == S_WAIT) && bus.inputs_ready && bus.neuron_done;
    assign bus.neuron_index = idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.inputs_ready) state_nxt = S_START;
            S_START: state_nxt = bus.inputs_ready ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!bus.inputs_ready) begin
                    state_nxt = S_IDLE;
                end else if (bus.neuron_done) begin
                    state_nxt = (idx == LAST_IDX) ? S_DONE : S_START;
                end
            end
            S_DONE:  if (!bus.inputs_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.neuron_start  = (state == S_START);
        bus.busy          = (state == S_START) || (state == S_WAIT);
        bus.outputs_ready = (state == S_DONE);
    end

    // Index is cleared on every idle/abort so a restart always begins at neuron 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else begin
            unique case (state)
                S_IDLE:  idx <= '0;
                S_START: if (!bus.inputs_ready) idx <= '0;
                S_WAIT: begin
                    if (!bus.inputs_ready) begin
                        idx <= '0;
                    end else if (bus.neuron_done && (idx != LAST_IDX)) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: idx <= idx;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                bus.outputs[i] <= '0;
            end
        end else if (accept) begin
            bus.outputs[idx] <= bus.neuron_out;
        end
    end

`ifdef LAYER_SEQUENCER_ARGMAX_EN
    data_t max_val;

    assign bus.max_value = max_val;

    // Strict greater-than keeps the lower index on ties.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.max_index <= '0;
            max_val       <= '0;
        end else if (accept) begin
            if ((idx == '0) || (bus.neuron_out > max_val)) begin
                bus.max_index <= idx;
                max_val       <= bus.neuron_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: behavioural engine models drive a 4-neuron
// and a 1-neuron instance; expected results come from a simple array model.
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef FRACTION_WIDTH
`define FRACTION_WIDTH 8
`endif

module tb_layer_sequencer;
    typedef logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH] data_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    initial forever #5 clock = ~clock;

    layer_sequencer_if #(.NUM_NEURONS(4)) if4 ();
    layer_sequencer_if #(.NUM_NEURONS(1)) if1 ();

    layer_sequencer #(.NUM_NEURONS(4)) dut4 (.clock(clock), .reset(reset), .bus(if4.master));
    layer_sequencer #(.NUM_NEURONS(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.master));

    int checks = 0;
    int errors = 0;

    data_t res4 [4];
    data_t exp4 [4];
    data_t res1 = '0;
    int    lat4 = 3;
    int    lat1 = 1;

    int    e4_cnt = 0;
    int    e4_idx = 0;
    logic  e4_done = 1'b0;
    data_t e4_val = '0;
    logic  spur4 = 1'b0;
    data_t spur_val = '0;
    int    e1_cnt = 0;
    logic  e1_done = 1'b0;
    data_t e1_val = '0;

    assign if4.neuron_done = e4_done | spur4;
    assign if4.neuron_out  = spur4 ? spur_val : e4_val;
    assign if1.neuron_done = e1_done;
    assign if1.neuron_out  = e1_val;

    // Engine model: result of the started index appears L cycles after the start pulse.
    initial forever begin
        @(posedge clock); #2;
        e4_done = 1'b0;
        if (reset || !if4.inputs_ready) begin
            e4_cnt = 0;
        end else if (if4.neuron_start) begin
            e4_cnt = lat4;
            e4_idx = int'(if4.neuron_index);
        end else if (e4_cnt > 0) begin
            e4_cnt--;
            if (e4_cnt == 0) begin
                e4_done = 1'b1;
                e4_val  = res4[e4_idx];
            end
        end
    end

    initial forever begin
        @(posedge clock); #2;
        e1_done = 1'b0;
        if (reset || !if1.inputs_ready) begin
            e1_cnt = 0;
        end else if (if1.neuron_start) begin
            e1_cnt = lat1;
        end else if (e1_cnt > 0) begin
            e1_cnt--;
            if (e1_cnt == 0) begin
                e1_done = 1'b1;
                e1_val  = res1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    function automatic int ready_cycle(input int n, input int l);
        return n * (l + 1) + 1;
    endfunction

    // Raise inputs_ready and count cycles until the layer vector is reported complete.
    task automatic run4(input int l, output int rdy_cycle, output int starts, output int max_idx);
        lat4 = l;
        if4.inputs_ready = 1'b1;
        rdy_cycle = -1;
        starts = 0;
        max_idx = 0;
        for (int e = 0; e < 400; e++) begin
            tick();
            if (if4.neuron_start) starts++;
            if (int'(if4.neuron_index) > max_idx) max_idx = int'(if4.neuron_index);
            if (if4.outputs_ready) begin
                rdy_cycle = e + 1;
                break;
            end
        end
    endtask

    task automatic drop4();
        if4.inputs_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        if4.inputs_ready = 1'b0;
        if1.inputs_ready = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({if4.busy, if4.neuron_start, if4.outputs_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl4: busy/start/ready=%b required 000",
                     {if4.busy, if4.neuron_start, if4.outputs_ready});
        end
        checks++;
        if ({if1.busy, if1.neuron_start, if1.outputs_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl1: busy/start/ready=%b required 000",
                     {if1.busy, if1.neuron_start, if1.outputs_ready});
        end
        checks++;
        if (if4.neuron_index !== 2'd0) begin
            errors++;
            $display("FAIL reset_index: got %0d required 0", if4.neuron_index);
        end
        for (int i = 0; i < 4; i++) begin
            exp4[i] = '0;
            checks++;
            if (if4.outputs[i] !== exp4[i]) begin
                errors++;
                $display("FAIL reset_out[%0d]: got %0d required 0", i, if4.outputs[i]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic check_outputs4(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if4.outputs[i] !== exp4[i]) begin
                errors++;
                $display("FAIL %s_out[%0d]: got %0d required %0d", name, i, if4.outputs[i], exp4[i]);
            end
        end
    endtask

    task automatic test_layer();
        int rdy, starts, mx;
        res4[0] = data_t'(256);    // 1.0
        res4[1] = data_t'(640);    // 2.5
        res4[2] = data_t'(-128);   // -0.5
        res4[3] = data_t'(768);    // 3.0
        run4(3, rdy, starts, mx);
        for (int i = 0; i < 4; i++) exp4[i] = res4[i];
        checks++;
        if (rdy !== 17) begin
            errors++;
            $display("FAIL layer_ready_cycle: got %0d required 17", rdy);
        end
        checks++;
        if (starts !== 4) begin
            errors++;
            $display("FAIL layer_starts: got %0d required 4", starts);
        end
        checks++;
        if (mx > 3) begin
            errors++;
            $display("FAIL layer_index_range: got %0d required <=3", mx);
        end
        check_outputs4("layer");
        drop4();
        checks++;
        if ({if4.outputs_ready, if4.busy} !== 2'b00) begin
            errors++;
            $display("FAIL layer_release: ready/busy=%b required 00", {if4.outputs_ready, if4.busy});
        end
    endtask

    task automatic test_random();
        int rdy, starts, mx, l;
        for (int r = 0; r < 4; r++) begin
            l = int'($urandom_range(1, 5));
            for (int i = 0; i < 4; i++) res4[i] = data_t'($urandom);
            run4(l, rdy, starts, mx);
            for (int i = 0; i < 4; i++) exp4[i] = res4[i];
            checks++;
            if (rdy !== ready_cycle(4, l)) begin
                errors++;
                $display("FAIL random_ready_cycle: L=%0d got %0d required %0d", l, rdy, ready_cycle(4, l));
            end
            checks++;
            if (starts !== 4) begin
                errors++;
                $display("FAIL random_starts: got %0d required 4", starts);
            end
            check_outputs4("random");
            drop4();
        end
    endtask

    task automatic test_single();
        int rdy = -1;
        int mx = 0;
        res1 = data_t'(768);       // 3.0
        lat1 = 1;
        if1.inputs_ready = 1'b1;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (int'(if1.neuron_index) > mx) mx = int'(if1.neuron_index);
            if (if1.outputs_ready) begin
                rdy = e + 1;
                break;
            end
        end
        checks++;
        if (rdy !== 3) begin
            errors++;
            $display("FAIL single_ready_cycle: got %0d required 3", rdy);
        end
        checks++;
        if (mx !== 0) begin
            errors++;
            $display("FAIL single_index: got %0d required 0", mx);
        end
        checks++;
        if (if1.outputs[0] !== res1) begin
            errors++;
            $display("FAIL single_out: got %0d required %0d", if1.outputs[0], res1);
        end
        if1.inputs_ready = 1'b0;
        tick();
    endtask

    task automatic test_spurious();
        int rdy, starts, mx;
        spur_val = data_t'(-12345);
        spur4 = 1'b1;
        tick();
        spur4 = 1'b0;
        tick();
        checks++;
        if ({if4.busy, if4.outputs_ready, if4.neuron_start} !== 3'b000) begin
            errors++;
            $display("FAIL spur_idle_state: busy/ready/start=%b required 000",
                     {if4.busy, if4.outputs_ready, if4.neuron_start});
        end
        check_outputs4("spur_idle");
        for (int i = 0; i < 4; i++) res4[i] = data_t'(100 * (i + 1));
        run4(2, rdy, starts, mx);
        for (int i = 0; i < 4; i++) exp4[i] = res4[i];
        spur4 = 1'b1;
        tick();
        spur4 = 1'b0;
        tick();
        checks++;
        if ({if4.outputs_ready, if4.busy} !== 2'b10) begin
            errors++;
            $display("FAIL spur_done_state: ready/busy=%b required 10", {if4.outputs_ready, if4.busy});
        end
        checks++;
        if (if4.neuron_index !== 2'd3) begin
            errors++;
            $display("FAIL spur_done_index: got %0d required 3", if4.neuron_index);
        end
        check_outputs4("spur_done");
        drop4();
    endtask

    task automatic test_abort();
        int rdy, starts, mx;
        bit found = 1'b0;
        for (int i = 0; i < 4; i++) res4[i] = ~exp4[i];
        lat4 = 3;
        if4.inputs_ready = 1'b1;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (if4.busy && !if4.neuron_start && (if4.neuron_index == 2'd2)) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_wait2: got not-found required WAIT on index 2");
        end
        drop4();
        exp4[0] = res4[0];
        exp4[1] = res4[1];
        checks++;
        if ({if4.busy, if4.outputs_ready} !== 2'b00) begin
            errors++;
            $display("FAIL abort_state: busy/ready=%b required 00", {if4.busy, if4.outputs_ready});
        end
        checks++;
        if (if4.neuron_index !== 2'd0) begin
            errors++;
            $display("FAIL abort_index: got %0d required 0", if4.neuron_index);
        end
        check_outputs4("abort_partial");
        for (int i = 0; i < 4; i++) res4[i] = res4[i] + data_t'(3);
        run4(3, rdy, starts, mx);
        for (int i = 0; i < 4; i++) exp4[i] = res4[i];
        checks++;
        if (rdy !== 17) begin
            errors++;
            $display("FAIL abort_restart_ready: got %0d required 17", rdy);
        end
        check_outputs4("abort_restart");
        drop4();
    endtask

    task automatic test_reset_midrun();
        int rdy, starts, mx;
        for (int i = 0; i < 4; i++) res4[i] = data_t'($urandom_range(1, 30000));
        lat4 = 3;
        if4.inputs_ready = 1'b1;
        repeat (6) tick();
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) exp4[i] = '0;
        checks++;
        if ({if4.busy, if4.neuron_start, if4.outputs_ready} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_ctrl: busy/start/ready=%b required 000",
                     {if4.busy, if4.neuron_start, if4.outputs_ready});
        end
        checks++;
        if (if4.neuron_index !== 2'd0) begin
            errors++;
            $display("FAIL midreset_index: got %0d required 0", if4.neuron_index);
        end
        check_outputs4("midreset");
        if4.inputs_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run4(2, rdy, starts, mx);
        for (int i = 0; i < 4; i++) exp4[i] = res4[i];
        checks++;
        if (rdy !== ready_cycle(4, 2)) begin
            errors++;
            $display("FAIL midreset_rerun_ready: got %0d required %0d", rdy, ready_cycle(4, 2));
        end
        check_outputs4("midreset_rerun");
        drop4();
    endtask

`ifdef LAYER_SEQUENCER_ARGMAX_EN
    task automatic test_argmax();
        int rdy, starts, mx, best;
        data_t vec [2][4];
        vec[0][0] = data_t'(512);  vec[0][1] = data_t'(1280);
        vec[0][2] = data_t'(1280); vec[0][3] = data_t'(-256);
        vec[1][0] = data_t'(-768); vec[1][1] = data_t'(-256);
        vec[1][2] = data_t'(-512); vec[1][3] = data_t'(-1024);
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 4; i++) res4[i] = vec[v][i];
            best = 0;
            for (int i = 1; i < 4; i++) if (res4[i] > res4[best]) best = i;
            run4(int'($urandom_range(1, 3)), rdy, starts, mx);
            checks++;
            if (int'(if4.max_index) !== best) begin
                errors++;
                $display("FAIL argmax_index[%0d]: got %0d required %0d", v, if4.max_index, best);
            end
            checks++;
            if (if4.max_value !== res4[best]) begin
                errors++;
                $display("FAIL argmax_value[%0d]: got %0d required %0d", v, if4.max_value, res4[best]);
            end
            drop4();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_layer();
        test_random();
        test_single();
        test_spurious();
        test_abort();
        test_reset_midrun();
`ifdef LAYER_SEQUENCER_ARGMAX_EN
        test_argmax();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Control block that time-shares one neuron engine (`neuron` datapath: multiply-accumulate plus activation) across all `NUM_NEURONS` outputs of a layer. Per neuron, it issues a start, waits for the engine's completion, and stores the result in an output register array. It raises `outputs_ready` once the full layer vector is valid. It sits between the previous layer's output handshake and the next layer's `inputs_ready`, and owns the weight/bias select index for the engine.

## Interface
Parameters:
- `NUM_NEURONS`, default 10: neurons in the layer, ≥1.
- Data width is `INTEGER_WIDTH + FRACTION_WIDTH`, taken from `include.svh`; it is not a parameter.

Ports:
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `inputs_ready`  in  1  level; layer input vector is valid and held stable while high.
- `neuron_index`  out  `$clog2(NUM_NEURONS)` (min 1)  index of the neuron currently assigned to the engine; selects weights/bias.
- `neuron_start`  out  1  one-cycle pulse that starts the engine.
- `neuron_done`  in  1  one-cycle pulse from the engine; result is valid on `neuron_out` in the same cycle.
- `neuron_out`  in  signed `[INTEGER_WIDTH-1:-FRACTION_WIDTH]`  engine result.
- `outputs`  out  signed `[INTEGER_WIDTH-1:-FRACTION_WIDTH]` × `NUM_NEURONS`  stored layer results.
- `outputs_ready`  out  1  level; `outputs` complete and stable.
- `busy`  out  1  high in START and WAIT.

## Operation
FSM states:
- IDLE: if `inputs_ready` = 1, set `neuron_index` = 0 and go to START.
- START: `neuron_start` = 1 for exactly this cycle, then go to WAIT.
- WAIT: hold `neuron_index`. On `neuron_done` = 1:
  - Write `outputs[neuron_index] <= neuron_out`.
  - If `neuron_index` == `NUM_NEURONS`-1, go to DONE.
  - Otherwise increment `neuron_index` and go to START.
- DONE: `outputs_ready` = 1. When `inputs_ready` = 0, go to IDLE and drop `outputs_ready`. While `inputs_ready` stays high, remain in DONE; the block does not recompute.

Rules:
- `neuron_done` is ignored outside WAIT.
- `inputs_ready` falling during START or WAIT aborts the run. Go to IDLE and clear `neuron_index`. `outputs` entries already written keep their values; `outputs_ready` stays 0.
- `outputs` entries are written only in WAIT on `neuron_done`. No arithmetic is performed on data; values pass through at full width.
- `neuron_index` never exceeds `NUM_NEURONS`-1. No wrap-around occurs.

## Timing
- Reset values: state IDLE, `neuron_index` 0, `neuron_start` 0, `outputs_ready` 0, `busy` 0, all `outputs` 0; `max_index` 0 and `max_value` 0 when enabled.
- All outputs are registered or decoded from the registered state only; there is no combinational path from any input to any output.
- Let `inputs_ready` be sampled high at edge 0:
  - `neuron_start` is high in cycle 1.
  - An engine with latency L asserts `neuron_done` L cycles after start, with L ≥ 1.
  - Per neuron: 1 START cycle + L WAIT cycles.
  - `outputs_ready` rises `NUM_NEURONS`·(L+1) + 1 cycles after edge 0.
- `neuron_done` in the first WAIT cycle (L = 1) is legal.
- Reset asserted mid-run returns everything to the reset values immediately, without waiting for a clock edge.

## Configuration
- `LAYER_SEQUENCER_ARGMAX_EN` defined adds outputs `max_index` (`neuron_index` width) and `max_value` (data width). Both are updated on each `neuron_done` accepted in WAIT:
  - Index 0 is loaded unconditionally.
  - Later indices replace the stored pair only if `neuron_out` > `max_value` (signed compare). Ties keep the lower index.
  - Both are valid while `outputs_ready` = 1.
- Undefined: the ports, compare logic and registers do not exist.

## Test plan
- NUM_NEURONS=4, engine model with L=3 returning 1.0, 2.5, −0.5, 3.0 → `outputs` = {1.0, 2.5, −0.5, 3.0}; `outputs_ready` at cycle 17; exactly 4 `neuron_start` pulses.
- L=1, NUM_NEURONS=1, result 3.0 → `outputs_ready` at cycle 3; `neuron_index` stays 0.
- Spurious `neuron_done` pulses in IDLE and DONE → `outputs` unchanged, no state change.
- `inputs_ready` dropped while WAITing on index 2 of 4 → IDLE next cycle, `outputs_ready` 0. Reasserting it restarts from index 0 and completes normally.
- `reset` pulsed between edges while in WAIT → immediate reset values; next run correct.
- ARGMAX_EN, outputs {2.0, 5.0, 5.0, −1.0} → `max_index` 1, `max_value` 5.0. All-negative {−3, −1, −2, −4} → `max_index` 1.
